// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore control FSM for the 4-bit subtract-and-compare GCD datapath; done = 4+2N cycles after go is sampled.
// No backpressure: go is taken only in IDLE, never queued. Define GCD_TIMEOUT_EN for the MAX_ITER step limit with err abort.
module gcd_ctrl #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic             equalflag,
  input  logic             lessthanflag,
  output logic             xmsel,
  output logic             ymsel,
  output logic             xld,
  output logic             yld,
  output logic             gld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_count,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUBX  = 3'd3,
    SUBY  = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
  } state_t;

`ifdef GCD_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] IterLimit = CNT_W'(MAX_ITER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d, iter_inc;
  logic             err_q, err_d;
  logic             timeout;
  logic             xmsel_q, ymsel_q, xld_q, yld_q, gld_q, busy_q, done_q;

  assign iter_inc = (iter_q == {CNT_W{1'b1}}) ? iter_q : iter_q + 1'b1;
  assign timeout  = TimeoutOn && (iter_q == IterLimit) && !equalflag;

  // Counter and err change on the edge that enters a state, so they are
  // already correct while the FSM sits in that state.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD:  state_d = CHECK;
      CHECK: begin
        if (equalflag) begin
          state_d = STORE;
        end else if (timeout) begin
          state_d = STORE;
          err_d   = 1'b1;
        end else if (lessthanflag) begin
          state_d = SUBY;
          iter_d  = iter_inc;
        end else begin
          state_d = SUBX;
          iter_d  = iter_inc;
        end
      end
      SUBX:    state_d = CHECK;
      SUBY:    state_d = CHECK;
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they stay aligned with state_q.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
      xmsel_q <= 1'b0;
      ymsel_q <= 1'b0;
      xld_q   <= 1'b0;
      yld_q   <= 1'b0;
      gld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      xmsel_q <= (state_d == LOAD);
      ymsel_q <= (state_d == LOAD);
      xld_q   <= (state_d == LOAD) || (state_d == SUBX);
      yld_q   <= (state_d == LOAD) || (state_d == SUBY);
      gld_q   <= (state_d == STORE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign xmsel      = xmsel_q;
  assign ymsel      = ymsel_q;
  assign xld        = xld_q;
  assign yld        = yld_q;
  assign gld        = gld_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iter_count = iter_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: drives a behavioural 4-bit GCD datapath and checks every cycle against a run-level model.
module tb_gcd_ctrl;
  localparam int CNT_W    = 8;
  localparam int MAX_ITER = 8;
`ifdef GCD_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0, clr = 1'b0, go = 1'b0;
  logic [3:0] xin = 4'd0, yin = 4'd0, xr = 4'd0, yr = 4'd0, gr = 4'd0;
  logic eqf, ltf;
  logic xmsel, ymsel, xld, yld, gld, busy, done, err;
  logic [CNT_W-1:0] iter_count;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [7:0] ctl;  // {xmsel,ymsel,xld,yld,gld,busy,done,err}
    int         iter;
  } exp_t;

  exp_t expq[$];
  int   idle_iter = 0;
  bit   idle_err  = 1'b0;
  bit   chk_en    = 1'b0;

  always #5 clk = ~clk;

  gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .clr(clr), .go(go), .equalflag(eqf), .lessthanflag(ltf),
    .xmsel(xmsel), .ymsel(ymsel), .xld(xld), .yld(yld), .gld(gld),
    .busy(busy), .done(done), .iter_count(iter_count), .err(err)
  );

  assign eqf = (xr == yr) || (xr == 4'd0) || (yr == 4'd0);
  assign ltf = (xr < yr);

  always @(posedge clk) begin
    if (xld) xr <= xmsel ? xin : xr - yr;
    if (yld) yr <= ymsel ? yin : yr - xr;
    if (gld) gr <= (xr == 4'd0 || yr == 4'd0) ? xr + yr : xr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit xm, ym, xl, yl, gl, bz, dn, er, input int it);
    exp_t e;
    e.ctl  = {xm, ym, xl, yl, gl, bz, dn, er};
    e.iter = it;
    return e;
  endfunction

  // Run-level model: plays out the subtract-and-compare algorithm on integers
  // and lists the control vector expected in each cycle of the run.
  task automatic push_run(input logic [3:0] a, input logic [3:0] b, output int n, output bit to);
    int x, y;
    x = a; y = b; n = 0; to = 1'b0;
    expq.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 0));
    while (!(x == y || x == 0 || y == 0)) begin
      if (TO && n == MAX_ITER) begin
        to = 1'b1;
        break;
      end
      expq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, n));
      n++;
      if (x < y) begin
        y = y - x;
        expq.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, n));
      end else begin
        x = x - y;
        expq.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, n));
      end
    end
    expq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, n));
    expq.push_back(mk(0, 0, 0, 0, 1, 1, 0, to, n));
    expq.push_back(mk(0, 0, 0, 0, 0, 1, 1, to, n));
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (expq.size() != 0) e = expq.pop_front();
      else e = mk(0, 0, 0, 0, 0, 0, 0, idle_err, idle_iter);
      idle_iter = e.iter;
      idle_err  = e.ctl[0];
      chk("cycle_ctl", 32'({xmsel, ymsel, xld, yld, gld, busy, done, err}), 32'(e.ctl));
      chk("cycle_iter", 32'(iter_count), 32'(e.iter));
    end
  end

  // One run; latency counts the go-sampling cycle as cycle 0.
  task automatic run(input logic [3:0] a, input logic [3:0] b, input int exp_g, input int exp_n,
                     input bit exp_err, input bit poke, input string nm);
    int n, lat;
    bit to;
    @(posedge clk); #1;
    xin = a; yin = b; go = 1'b1;
    @(posedge clk);
    push_run(a, b, n, to);
    #1 go = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (poke) go = (lat == 3 || lat == 4);
    end
    chk({nm, "_latency"}, 32'(lat), 32'(4 + 2 * exp_n));
    chk({nm, "_iter"}, 32'(iter_count), 32'(exp_n));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    if (!exp_err) chk({nm, "_gcd"}, 32'(gr), 32'(exp_g));
    if (poke) begin
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      chk({nm, "_go_in_done_ignored"}, 32'(busy), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, dn, lds;
    bit to;
    // Asynchronous reset before any clock edge.
    #1 clr = 1'b1;
    #1;
    chk("reset_ctl", 32'({xmsel, ymsel, xld, yld, gld, busy, done, err}), 32'(0));
    chk("reset_iter", 32'(iter_count), 32'(0));
    @(posedge clk); #1 clr = 1'b0;
    chk_en = 1'b1;

    run(4'd12, 4'd8, 4, 2, 1'b0, 1'b0, "r12_8");
    run(4'd9, 4'd9, 9, 0, 1'b0, 1'b0, "r9_9");
    run(4'd0, 4'd5, 5, 0, 1'b0, 1'b0, "r0_5");
    run(4'd0, 4'd0, 0, 0, 1'b0, 1'b0, "r0_0");
    run(4'd3, 4'd13, 1, 6, 1'b0, 1'b0, "r3_13");
    run(4'd15, 4'd1, 1, TO ? MAX_ITER : 14, TO, 1'b0, "r15_1");
    run(4'd12, 4'd8, 4, 2, 1'b0, 1'b1, "poke12_8");

    // clr in the middle of a SUBX step: immediate return to IDLE, no done.
    @(posedge clk); #1;
    xin = 4'd15; yin = 4'd1; go = 1'b1;
    @(posedge clk);
    push_run(4'd15, 4'd1, n, to);
    #1 go = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_run_in_subx", 32'({xld, xmsel}), 32'(2'b10));
    #2 clr = 1'b1;
    expq.delete();
    idle_iter = 0;
    idle_err  = 1'b0;
    #1;
    chk("clr_async_ctl", 32'({xmsel, ymsel, xld, yld, gld, busy, done, err}), 32'(0));
    chk("clr_async_iter", 32'(iter_count), 32'(0));
    @(posedge clk); #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    run(4'd12, 4'd8, 4, 2, 1'b0, 1'b0, "after_clr");

    // go held high: three back-to-back runs with one IDLE cycle between.
    @(posedge clk); #1;
    xin = 4'd9; yin = 4'd6; go = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      push_run(4'd9, 4'd6, n, to);
      if (r < 2) expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, to, n));
    end
    #1;
    dn = 0; lds = 1; lat = 0;
    while (dn < 3 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) dn++;
      if (xld && xmsel) begin
        lds++;
        if (lds == 3) go = 1'b0;
      end
    end
    chk("b2b_done_count", 32'(dn), 32'(3));
    chk("b2b_cycles", 32'(lat), 32'(3 * 8 + 2 - 1));
    chk("b2b_gcd", 32'(gr), 32'(3));

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", 32'(expq.size()), 32'(0));
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
